store_queue: RTL

Parametrised successor to the MEM-stage store write-enable logic. Decodes store opcodes into byte strobes, aligned write data and an address-error flag, then buffers accepted stores in a DEPTH-entry FIFO. The FIFO drains to the data SRAM-like bus with a req/addr_ok/data_ok handshake, one transaction outstanding. Sits between the MEM stage and the data bus bridge, and stalls loads that hit a pending store.

---
 rtl/store_queue.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/store_queue.sv
// Store queue: decodes SB/SH/SW into byte strobes and lane-aligned data, buffers them
// in a DEPTH-entry FIFO and drains one at a time over a req/addr_ok/data_ok bus.
// Optional feature macro: SWLR_EN adds SWL/SWR (unaligned partial-word stores).
module store_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [5:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt_data,
  input  logic              flush,
  output logic              st_ready,
  output logic              ades,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_conflict,
  output logic              empty,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
`ifdef SWLR_EN
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SWR = 6'b101110;
`endif
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic              w_is_st;
  logic              w_ades;
  logic [1:0]        w_size;
  logic [3:0]        w_strb;
  logic [31:0]       w_wdata;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_a;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_req;
  logic              w_hit;
  logic              w_unused;

  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [1:0]        r_q_size [DEPTH];
  logic [3:0]        r_q_strb [DEPTH];
  logic [31:0]       r_q_data [DEPTH];
  logic [DEPTH-1:0]  r_q_vld;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW:0]       r_count;
  logic [1:0]        r_state;

  assign w_a      = addr[1:0];
  assign w_unused = ^ld_addr[1:0];

  // Store decode: strobes, lane replication and misalignment detection
  always_comb begin
    w_is_st = 1'b0;
    w_ades  = 1'b0;
    w_size  = 2'd0;
    w_strb  = 4'b0000;
    w_wdata = 32'h0000_0000;
    w_addr  = addr;
    case (op)
      OP_SB: begin
        w_is_st = 1'b1;
        w_size  = 2'd0;
        w_strb  = 4'b0001 << w_a;
        w_wdata = {4{rt_data[7:0]}};
      end
      OP_SH: begin
        w_is_st = 1'b1;
        w_size  = 2'd1;
        w_wdata = {2{rt_data[15:0]}};
        if (w_a[0]) begin
          w_ades = st_valid;
        end else begin
          w_strb = w_a[1] ? 4'b1100 : 4'b0011;
        end
      end
      OP_SW: begin
        w_is_st = 1'b1;
        w_size  = 2'd2;
        w_wdata = rt_data;
        if (w_a != 2'd0) begin
          w_ades = st_valid;
        end else begin
          w_strb = 4'b1111;
        end
      end
`ifdef SWLR_EN
      OP_SWL: begin
        w_is_st = 1'b1;
        w_size  = 2'd2;
        w_addr  = {addr[ADDR_W-1:2], 2'b00};
        w_strb  = 4'b1111 >> (2'd3 - w_a);
        w_wdata = rt_data >> {(2'd3 - w_a), 3'b000};
      end
      OP_SWR: begin
        w_is_st = 1'b1;
        w_size  = 2'd2;
        w_addr  = {addr[ADDR_W-1:2], 2'b00};
        w_strb  = 4'b1111 << w_a;
        w_wdata = rt_data << {w_a, 3'b000};
      end
`endif
      default: begin
        w_is_st = 1'b0;
      end
    endcase
  end

  assign ades     = w_ades;
  assign w_full   = (r_count == FULL_CNT);
  assign st_ready = !w_full;
  assign w_push   = st_valid && w_is_st && !w_ades && !flush && !w_full;
  assign w_pop    = (r_state == S_WAIT) && data_data_ok;
  assign empty    = (r_count == '0);

  // Entry payload; the valid bit and pointers below qualify it
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= w_addr;
      r_q_size[r_wr_ptr] <= w_size;
      r_q_strb[r_wr_ptr] <= w_strb;
      r_q_data[r_wr_ptr] <= w_wdata;
    end
  end

  // Pointers, occupancy and drain FSM; the head stays valid until its data_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_q_vld  <= '0;
      r_state  <= S_IDLE;
    end else begin
      if (w_push) begin
        r_wr_ptr          <= r_wr_ptr + PW'(1);
        r_q_vld[r_wr_ptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + PW'(1);
        r_q_vld[r_rd_ptr] <= 1'b0;
      end
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      case (r_state)
        S_IDLE:  if (r_count != '0) r_state <= S_REQ;
        S_REQ:   if (data_addr_ok) r_state <= S_WAIT;
        S_WAIT:  if (data_data_ok) r_state <= ((r_count > ONE_CNT) || w_push) ? S_REQ : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_req      = (r_state == S_REQ);
  assign data_req   = w_req;
  assign data_wr    = w_req;
  assign data_addr  = w_req ? r_q_addr[r_rd_ptr] : '0;
  assign data_size  = w_req ? r_q_size[r_rd_ptr] : 2'd0;
  assign data_wstrb = w_req ? r_q_strb[r_rd_ptr] : 4'b0000;
  assign data_wdata = w_req ? r_q_data[r_rd_ptr] : 32'h0000_0000;

  // Word-address match against every occupied slot, in-flight head included
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit = w_hit | (r_q_vld[i] && (r_q_addr[i][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]));
    end
  end

  assign ld_conflict = ld_valid & w_hit;
endmodule
